ddr4_port_arb: RTL and testbench

- Multi-port front-end arbiter that shares the single CPU-side interface of the DDR4 controller (crd/cwr/ca/cwdat/crdat) between NPORT requesters.
- Picks one requester per transaction using round-robin, with bounded row-hit preference driven by a per-bank open-row table.
- Holds the chosen command stable until the controller reports completion, then returns data and a done/err pulse to the winner.
- Sits between the system-side masters and the DDR4 controller.

---
 rtl/ddr4_pkg.sv | 37 +++
 rtl/ddr4_port_arb_rr_pick.sv | 38 +++
 rtl/ddr4_port_arb.sv | 171 +++++++++++++++++
 tb/tb_ddr4_port_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// ============================================================================
// Module   : ddr4_pkg
// Brief    : Shared address-field constants, FSM encoding and open-row entry
//            type for the DDR4 port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr4_pkg;

  localparam int ADDR_W    = 31;
  localparam int DATA_W    = 4;

  // Address layout: {bg[30:29], ba[28:27], row[26:10], col[9:0]}
  localparam int BG_MSB    = 30;
  localparam int BA_MSB    = 28;
  localparam int BANK_LSB  = 27;
  localparam int ROW_MSB   = 26;
  localparam int ROW_LSB   = 10;
  localparam int COL_MSB   = 9;
  localparam int ROW_W     = ROW_MSB - ROW_LSB + 1;
  localparam int BANK_W    = BG_MSB - BANK_LSB + 1;
  localparam int TBL_DEPTH = 1 << BANK_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic             vld;
    logic [ROW_W-1:0] row;
  } tbl_entry_t;

  localparam int TBL_W = $bits(tbl_entry_t);

endpackage

`default_nettype wire

// File: rtl/ddr4_port_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request bit at or
//            after the pointer, returned one-hot with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    o_gnt = '0;
    w_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

  assign o_vld = |i_req;

endmodule

`default_nettype wire

// File: rtl/ddr4_port_arb.sv
// ============================================================================
// Module   : ddr4_port_arb
// Brief    : Round-robin DDR4 front-end arbiter with bounded row-hit preference
//            and a per-transaction completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr4_port_arb
  import ddr4_pkg::*;
#(
  parameter int NPORT          = 4,
  parameter int MAX_HIT_STREAK = 4,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clkin,
  input  logic                      crst,
  input  logic [NPORT-1:0]          p_req,
  input  logic [NPORT-1:0]          p_wr,
  input  logic [NPORT*ADDR_W-1:0]   p_addr,
  input  logic [NPORT*DATA_W-1:0]   p_wdat,
  output logic [NPORT-1:0]          p_gnt,
  output logic [NPORT-1:0]          p_done,
  output logic                      p_err,
  output logic [DATA_W-1:0]         p_rdat,
  output logic                      crd,
  output logic                      cwr,
  output logic [ADDR_W-1:0]         ca,
  output logic [DATA_W-1:0]         cwdat,
  input  logic [DATA_W-1:0]         crdat,
  input  logic                      c_done,
  output logic                      busy
);

  localparam int c_pw = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int c_sw = $clog2(MAX_HIT_STREAK + 1);
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_sw-1:0] c_max_streak = c_sw'(MAX_HIT_STREAK);
  localparam logic [c_tw-1:0] c_tmo_last   = c_tw'(TIMEOUT - 1);

  logic [0:0]        r_state, w_state_nxt;
  logic [c_pw-1:0]   r_rr, r_win, w_win_idx, w_rr_nxt;
  logic [c_sw-1:0]   r_streak;
  logic [c_tw-1:0]   r_tmo;
  logic [ADDR_W-1:0] r_addr, w_win_addr;
  logic [DATA_W-1:0] r_wdat, w_win_wdat, r_rdat;
  logic              r_wr, w_win_wr, r_err;
  logic [NPORT-1:0]  r_gnt, r_done;
  logic [NPORT-1:0]  w_hit, w_gnt_hit, w_gnt_req, w_gnt;
  logic              w_vld_hit, w_vld_req, w_use_hit, w_tmo_hit;
  tbl_entry_t        r_tbl [TBL_DEPTH];

  for (genvar i = 0; i < NPORT; i++) begin : g_hit
    tbl_entry_t w_ent;
    assign w_ent    = r_tbl[p_addr[ADDR_W*i+BANK_LSB +: BANK_W]];
    assign w_hit[i] = p_req[i] && w_ent.vld &&
                      (w_ent.row == p_addr[ADDR_W*i+ROW_LSB +: ROW_W]);
  end

  rr_pick #(.N(NPORT), .PW(c_pw)) u_pick_hit (
    .i_req(w_hit), .i_ptr(r_rr), .o_gnt(w_gnt_hit), .o_vld(w_vld_hit)
  );

  rr_pick #(.N(NPORT), .PW(c_pw)) u_pick_req (
    .i_req(p_req), .i_ptr(r_rr), .o_gnt(w_gnt_req), .o_vld(w_vld_req)
  );

  assign w_use_hit = w_vld_hit && (r_streak < c_max_streak);
  assign w_gnt     = w_use_hit ? w_gnt_hit : w_gnt_req;
  assign w_tmo_hit = (r_tmo == c_tmo_last);
  assign w_rr_nxt  = (r_win == c_pw'(NPORT - 1)) ? '0 : r_win + 1'b1;

  always_comb begin
    w_win_idx  = '0;
    w_win_addr = '0;
    w_win_wdat = '0;
    w_win_wr   = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_gnt[i]) begin
        w_win_idx  = c_pw'(i);
        w_win_addr = p_addr[ADDR_W*i +: ADDR_W];
        w_win_wdat = p_wdat[DATA_W*i +: DATA_W];
        w_win_wr   = p_wr[i];
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (crst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_vld_req) w_state_nxt = ST_BUSY;
      ST_BUSY: if (c_done || w_tmo_hit) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    crd   = 1'b0;
    cwr   = 1'b0;
    ca    = '0;
    cwdat = '0;
    if (r_state == ST_BUSY) begin
      busy  = 1'b1;
      crd   = !r_wr;
      cwr   = r_wr;
      ca    = r_addr;
      cwdat = r_wdat;
    end
  end

  always_ff @(posedge clkin) begin
    if (crst) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdat   <= '0;
      r_rr     <= '0;
      r_win    <= '0;
      r_streak <= '0;
      r_tmo    <= '0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_wr     <= 1'b0;
      for (int e = 0; e < TBL_DEPTH; e++) r_tbl[e].vld <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_rdat <= '0;
      if (r_state == ST_IDLE) begin
        if (w_vld_req) begin
          r_gnt    <= w_gnt;
          r_win    <= w_win_idx;
          r_addr   <= w_win_addr;
          r_wdat   <= w_win_wdat;
          r_wr     <= w_win_wr;
          r_tmo    <= '0;
          r_streak <= w_use_hit ? r_streak + 1'b1 : '0;
        end
      end else begin
        r_tmo <= r_tmo + 1'b1;
        // c_done takes priority over a coincident timeout
        if (c_done) begin
          r_done                            <= NPORT'(1) << r_win;
          r_rdat                            <= r_wr ? '0 : crdat;
          r_tbl[r_addr[BG_MSB:BANK_LSB]]    <= '{vld: 1'b1, row: r_addr[ROW_MSB:ROW_LSB]};
          r_rr                              <= w_rr_nxt;
        end else if (w_tmo_hit) begin
          r_done                            <= NPORT'(1) << r_win;
          r_err                             <= 1'b1;
          r_tbl[r_addr[BG_MSB:BANK_LSB]].vld <= 1'b0;
          r_rr                              <= w_rr_nxt;
        end
      end
    end
  end

  assign p_gnt  = r_gnt;
  assign p_done = r_done;
  assign p_err  = r_err;
  assign p_rdat = r_rdat;

endmodule

`default_nettype wire

// File: tb/tb_ddr4_port_arb.sv
// ============================================================================
// Module   : tb_ddr4_port_arb
// Brief    : Directed self-checking bench for ddr4_port_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr4_port_arb;

  localparam int NPORT   = 4;
  localparam int TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         crst;
  logic [3:0]   p_req, p_wr, p_gnt, p_done, p_rdat, cwdat, crdat;
  logic [123:0] p_addr;
  logic [15:0]  p_wdat;
  logic         p_err, crd, cwr, c_done, busy;
  logic [30:0]  ca;
  int           n_pass = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  ddr4_port_arb #(.NPORT(NPORT), .MAX_HIT_STREAK(4), .TIMEOUT(TIMEOUT)) dut (
    .clkin(clk), .crst(crst), .p_req(p_req), .p_wr(p_wr), .p_addr(p_addr),
    .p_wdat(p_wdat), .p_gnt(p_gnt), .p_done(p_done), .p_err(p_err),
    .p_rdat(p_rdat), .crd(crd), .cwr(cwr), .ca(ca), .cwdat(cwdat),
    .crdat(crdat), .c_done(c_done), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic wr, input logic [30:0] a, input logic [3:0] d);
    p_wr[i]          = wr;
    p_addr[31*i +: 31] = a;
    p_wdat[4*i +: 4]   = d;
  endtask

  task automatic do_reset;
    p_req  = '0;
    c_done = 1'b0;
    crst   = 1'b1;
    tick;
    tick;
    crst   = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] d);
    c_done = 1'b1;
    crdat  = d;
    tick;
    c_done = 1'b0;
    crdat  = '0;
  endtask

  task automatic test_reset;
    crst = 1'b1;
    tick;
    tick;
    n_total++;
    if ({p_gnt, p_done, p_err, p_rdat} !== 13'h0) $display("FAIL reset_pulses: got %h exp 0", {p_gnt, p_done, p_err, p_rdat});
    else n_pass++;
    n_total++;
    if ({crd, cwr, busy, ca, cwdat} !== 38'h0) $display("FAIL reset_ctrl: got %h exp 0", {crd, cwr, busy, ca, cwdat});
    else n_pass++;
    crst = 1'b0;
  endtask

  task automatic test_single_read;
    set_port(2, 1'b0, 31'h0000_0400, 4'h0);
    p_req = 4'b0100;
    tick;
    n_total++;
    if ({p_gnt, crd, cwr, busy} !== 7'b0100_101) $display("FAIL read_gnt: got %b exp 0100101", {p_gnt, crd, cwr, busy});
    else n_pass++;
    n_total++;
    if (ca !== 31'h0000_0400) $display("FAIL read_ca: got %h exp 00000400", ca);
    else n_pass++;
    tick;
    tick;
    n_total++;
    if ({p_gnt, crd, ca} !== {4'b0000, 1'b1, 31'h0000_0400}) $display("FAIL read_hold: got %h exp %h", {p_gnt, crd, ca}, {4'b0000, 1'b1, 31'h0000_0400});
    else n_pass++;
    pulse_done(4'hA);
    n_total++;
    if ({p_done, p_rdat, crd, p_err, busy} !== 11'b0100_1010_000) $display("FAIL read_done: got %b exp 01001010000", {p_done, p_rdat, crd, p_err, busy});
    else n_pass++;
    p_req = '0;
    tick;
    n_total++;
    if ({p_done, p_rdat} !== 8'h00) $display("FAIL read_pulse_end: got %h exp 00", {p_done, p_rdat});
    else n_pass++;
  endtask

  task automatic test_rr_order;
    int         ord [5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    do_reset;
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, {4'(i + 1), 17'(i + 20), 10'h0}, 4'h0);
    p_req = 4'hF;
    tick;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << ord[k];
      n_total++;
      if (p_gnt !== e) $display("FAIL rr_gnt%0d: got %b exp %b", k, p_gnt, e);
      else n_pass++;
      tick;
      tick;
      pulse_done(4'(k));
      n_total++;
      if ({p_gnt, p_done} !== {4'b0000, e}) $display("FAIL rr_done%0d: got %b exp %b", k, {p_gnt, p_done}, {4'b0000, e});
      else n_pass++;
      p_req[ord[k]] = 1'b0;
      if (k == 0) set_port(0, 1'b0, {4'd1, 17'd99, 10'h0}, 4'h0);
      tick;
      if (k == 0) p_req[0] = 1'b1;
    end
  endtask

  task automatic test_row_hit;
    do_reset;
    set_port(0, 1'b0, {4'd0, 17'd5, 10'd0}, 4'h0);
    p_req = 4'b0001;
    tick;
    tick;
    pulse_done(4'h1);
    p_req = '0;
    tick;
    set_port(1, 1'b0, {4'd0, 17'd9, 10'd3}, 4'h0);
    set_port(3, 1'b0, {4'd0, 17'd5, 10'd7}, 4'h0);
    p_req = 4'b1010;
    tick;
    n_total++;
    if ({p_gnt, ca} !== {4'b1000, 4'd0, 17'd5, 10'd7}) $display("FAIL hit_first: got %h exp %h", {p_gnt, ca}, {4'b1000, 4'd0, 17'd5, 10'd7});
    else n_pass++;
    tick;
    pulse_done(4'h2);
    p_req[3] = 1'b0;
    tick;
    n_total++;
    if (p_gnt !== 4'b0010) $display("FAIL hit_second: got %b exp 0010", p_gnt);
    else n_pass++;
    tick;
    pulse_done(4'h3);
    p_req = '0;
    tick;
  endtask

  task automatic test_hit_streak;
    int         ord [5] = '{0, 1, 0, 1, 2};
    logic [3:0] e;
    do_reset;
    set_port(1, 1'b0, {4'd0, 17'd7, 10'd0}, 4'h0);
    p_req = 4'b0010;
    tick;
    tick;
    pulse_done(4'h0);
    p_req = '0;
    tick;
    set_port(0, 1'b0, {4'd0, 17'd7, 10'd1}, 4'h0);
    set_port(1, 1'b0, {4'd0, 17'd7, 10'd2}, 4'h0);
    set_port(2, 1'b0, {4'd0, 17'd8, 10'd0}, 4'h0);
    p_req = 4'b0111;
    tick;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << ord[k];
      n_total++;
      if (p_gnt !== e) $display("FAIL streak_gnt%0d: got %b exp %b", k, p_gnt, e);
      else n_pass++;
      tick;
      pulse_done(4'h0);
      if (k == 4) p_req = '0;
      else p_req[ord[k]] = 1'b0;
      tick;
      if (k < 4) p_req[ord[k]] = 1'b1;
    end
  endtask

  task automatic test_timeout;
    int cnt;
    do_reset;
    set_port(1, 1'b1, {4'd2, 17'd3, 10'd0}, 4'h5);
    p_req = 4'b0010;
    tick;
    tick;
    pulse_done(4'h0);
    p_req = '0;
    tick;
    set_port(1, 1'b1, {4'd2, 17'd3, 10'd0}, 4'hC);
    p_req = 4'b0010;
    tick;
    n_total++;
    if ({p_gnt, crd, cwr, cwdat} !== 10'b0010_01_1100) $display("FAIL tmo_gnt: got %b exp 0010011100", {p_gnt, crd, cwr, cwdat});
    else n_pass++;
    p_req = '0;
    cnt = 0;
    while (p_done === 4'b0000 && cnt < TIMEOUT + 8) begin
      tick;
      cnt++;
    end
    n_total++;
    if (cnt !== TIMEOUT) $display("FAIL tmo_latency: got %0d exp %0d", cnt, TIMEOUT);
    else n_pass++;
    n_total++;
    if ({p_done, p_err, crd, cwr, busy} !== 8'b0010_1000) $display("FAIL tmo_done: got %b exp 00101000", {p_done, p_err, crd, cwr, busy});
    else n_pass++;
    tick;
    set_port(1, 1'b0, {4'd2, 17'd3, 10'd0}, 4'h0);
    set_port(2, 1'b0, {4'd2, 17'd11, 10'd0}, 4'h0);
    p_req = 4'b0110;
    tick;
    n_total++;
    if (p_gnt !== 4'b0100) $display("FAIL tmo_no_hit: got %b exp 0100", p_gnt);
    else n_pass++;
    tick;
    pulse_done(4'h0);
    n_total++;
    if ({p_done, p_err} !== 5'b0100_0) $display("FAIL tmo_next_done: got %b exp 01000", {p_done, p_err});
    else n_pass++;
    p_req[2] = 1'b0;
    tick;
    tick;
    pulse_done(4'h0);
    p_req = '0;
    tick;
  endtask

  task automatic test_reset_mid_busy;
    set_port(3, 1'b0, {4'd5, 17'd1, 10'd0}, 4'h0);
    p_req = 4'b1000;
    tick;
    n_total++;
    if (p_gnt !== 4'b1000) $display("FAIL mid_gnt: got %b exp 1000", p_gnt);
    else n_pass++;
    tick;
    crst = 1'b1;
    tick;
    n_total++;
    if ({crd, cwr, busy, p_gnt, p_done, p_err} !== 12'h000) $display("FAIL mid_reset: got %b exp 0", {crd, cwr, busy, p_gnt, p_done, p_err});
    else n_pass++;
    crst  = 1'b0;
    p_req = '0;
    tick;
    tick;
    n_total++;
    if ({p_done, p_err} !== 5'b0) $display("FAIL mid_no_done: got %b exp 00000", {p_done, p_err});
    else n_pass++;
    set_port(1, 1'b0, {4'd6, 17'd2, 10'd0}, 4'h0);
    p_req = 4'b1010;
    tick;
    n_total++;
    if (p_gnt !== 4'b0010) $display("FAIL post_reset_rr: got %b exp 0010", p_gnt);
    else n_pass++;
    tick;
    pulse_done(4'h0);
    p_req = '0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    crst   = 1'b1;
    p_req  = '0;
    p_wr   = '0;
    p_addr = '0;
    p_wdat = '0;
    crdat  = '0;
    c_done = 1'b0;
    test_reset;
    test_single_read;
    test_rr_order;
    test_row_hit;
    test_hit_streak;
    test_timeout;
    test_reset_mid_busy;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
